// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - pipeline-register fields in, forwarding/stall controls out
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rs1_IFID;
  logic [REG_AW-1:0] rs2_IFID;
  logic              uses_rs2_IFID;
  logic [REG_AW-1:0] rs1_IDEX;
  logic [REG_AW-1:0] rs2_IDEX;
  logic [REG_AW-1:0] rd_IDEX;
  logic              ID_EX_MemRead;
  logic [REG_AW-1:0] rd_EXMEM;
  logic              EX_MEM_RegW;
  logic [REG_AW-1:0] rd_MEMWB;
  logic              MEM_WB_RegW;
  logic [1:0]        MuxA;
  logic [1:0]        MuxB;
  logic              stall;
  logic              flush_IDEX;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output rs1_IFID, rs2_IFID, uses_rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX,
           ID_EX_MemRead, rd_EXMEM, EX_MEM_RegW, rd_MEMWB, MEM_WB_RegW,
    input  MuxA, MuxB, stall, flush_IDEX, stall_count
  );

  modport slave (
    input  rs1_IFID, rs2_IFID, uses_rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX,
           ID_EX_MemRead, rd_EXMEM, EX_MEM_RegW, rd_MEMWB, MEM_WB_RegW,
    output MuxA, MuxB, stall, flush_IDEX, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding, load-use stall sequencer, stall counter
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  hazard_forward_unit_if.slave bus
);
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] count;
  logic             haz;
  logic             stall_fsm;
  logic             stall_int;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              ex_w,
    input logic [REG_AW-1:0] ex_rd,
    input logic              wb_w,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_w && ex_rd != '0 && ex_rd == rs)
      sel = 2'b10;
    else if (wb_w && wb_rd != '0 && wb_rd == rs)
      sel = 2'b01;
    return sel;
  endfunction

  assign bus.MuxA = fwd_sel(bus.rs1_IDEX, bus.EX_MEM_RegW, bus.rd_EXMEM,
                            bus.MEM_WB_RegW, bus.rd_MEMWB);
  assign bus.MuxB = fwd_sel(bus.rs2_IDEX, bus.EX_MEM_RegW, bus.rd_EXMEM,
                            bus.MEM_WB_RegW, bus.rd_MEMWB);

  assign haz = bus.ID_EX_MemRead && (bus.rd_IDEX != '0) &&
               ((bus.rd_IDEX == bus.rs1_IFID) ||
                (bus.uses_rs2_IFID && (bus.rd_IDEX == bus.rs2_IFID)));

  // The first stall cycle is spent in IDLE, so HOLD covers the remaining LOAD_LAT-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_fsm = 1'b0;
    case (state)
      IDLE: begin
        if (haz) begin
          stall_fsm = 1'b1;
          if (LOAD_LAT > 1) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(LOAD_LAT - 2);
          end
        end
      end
      HOLD: begin
        stall_fsm = 1'b1;
        if (cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stall_int      = stall_fsm && !reset;
  assign bus.stall      = stall_int;
  assign bus.flush_IDEX = stall_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (stall_int && count != '1)
      count <= count + CNT_W'(1);
  end

  assign bus.stall_count = count;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed scoreboard bench over three parameterisations
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX, rd_EXMEM, rd_MEMWB;
  logic       uses_rs2_IFID, ID_EX_MemRead, EX_MEM_RegW, MEM_WB_RegW;

  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) i1 ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) i3 ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(4))  i4 ();

  assign i1.rs1_IFID = rs1_IFID;           assign i3.rs1_IFID = rs1_IFID;           assign i4.rs1_IFID = rs1_IFID;
  assign i1.rs2_IFID = rs2_IFID;           assign i3.rs2_IFID = rs2_IFID;           assign i4.rs2_IFID = rs2_IFID;
  assign i1.uses_rs2_IFID = uses_rs2_IFID; assign i3.uses_rs2_IFID = uses_rs2_IFID; assign i4.uses_rs2_IFID = uses_rs2_IFID;
  assign i1.rs1_IDEX = rs1_IDEX;           assign i3.rs1_IDEX = rs1_IDEX;           assign i4.rs1_IDEX = rs1_IDEX;
  assign i1.rs2_IDEX = rs2_IDEX;           assign i3.rs2_IDEX = rs2_IDEX;           assign i4.rs2_IDEX = rs2_IDEX;
  assign i1.rd_IDEX = rd_IDEX;             assign i3.rd_IDEX = rd_IDEX;             assign i4.rd_IDEX = rd_IDEX;
  assign i1.ID_EX_MemRead = ID_EX_MemRead; assign i3.ID_EX_MemRead = ID_EX_MemRead; assign i4.ID_EX_MemRead = ID_EX_MemRead;
  assign i1.rd_EXMEM = rd_EXMEM;           assign i3.rd_EXMEM = rd_EXMEM;           assign i4.rd_EXMEM = rd_EXMEM;
  assign i1.EX_MEM_RegW = EX_MEM_RegW;     assign i3.EX_MEM_RegW = EX_MEM_RegW;     assign i4.EX_MEM_RegW = EX_MEM_RegW;
  assign i1.rd_MEMWB = rd_MEMWB;           assign i3.rd_MEMWB = rd_MEMWB;           assign i4.rd_MEMWB = rd_MEMWB;
  assign i1.MEM_WB_RegW = MEM_WB_RegW;     assign i3.MEM_WB_RegW = MEM_WB_RegW;     assign i4.MEM_WB_RegW = MEM_WB_RegW;

  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) dut3 (.clk(clk), .reset(reset), .bus(i3.slave));
  hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(i4.slave));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic expect_v(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_IFID = 0; rs2_IFID = 0; uses_rs2_IFID = 0;
    rs1_IDEX = 0; rs2_IDEX = 0; rd_IDEX = 0; ID_EX_MemRead = 0;
    rd_EXMEM = 0; EX_MEM_RegW = 0; rd_MEMWB = 0; MEM_WB_RegW = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Hazard and a forwarding match present while reset is held
    ID_EX_MemRead = 1; rd_IDEX = 3; rs1_IFID = 3;
    rs1_IDEX = 5; rd_EXMEM = 5; EX_MEM_RegW = 1;
    expect_v("rst_stall1", 0); expect_v("rst_flush1", 0); expect_v("rst_stall3", 0);
    expect_v("rst_cnt1", 0); expect_v("rst_cnt4", 0); expect_v("rst_muxa", 2);
    @(negedge clk);
    check_v(32'(i1.stall)); check_v(32'(i1.flush_IDEX)); check_v(32'(i3.stall));
    check_v(32'(i1.stall_count)); check_v(32'(i4.stall_count)); check_v(32'(i1.MuxA));

    next_cycle();
    clear_inputs();
    reset = 1'b0;

    next_cycle();
    rs1_IDEX = 5; rd_EXMEM = 5; EX_MEM_RegW = 1; rd_MEMWB = 5; MEM_WB_RegW = 1;
    expect_v("prio_exmem", 2);
    @(negedge clk); check_v(32'(i1.MuxA));

    next_cycle();
    EX_MEM_RegW = 0;
    expect_v("prio_memwb", 1);
    @(negedge clk); check_v(32'(i1.MuxA));

    next_cycle();
    clear_inputs();
    rs2_IDEX = 0; rd_EXMEM = 0; EX_MEM_RegW = 1; rd_MEMWB = 0; MEM_WB_RegW = 1;
    expect_v("x0_muxb", 0);
    @(negedge clk); check_v(32'(i1.MuxB));

    next_cycle();
    clear_inputs();
    rs1_IDEX = 7; rs2_IDEX = 7; rd_MEMWB = 7; MEM_WB_RegW = 1;
    expect_v("both_muxa", 1); expect_v("both_muxb", 1); expect_v("fwd_nostall", 0);
    @(negedge clk); check_v(32'(i1.MuxA)); check_v(32'(i1.MuxB)); check_v(32'(i1.stall));

    // Load-use with a simultaneous EX/MEM match on the EX operand
    next_cycle();
    clear_inputs();
    ID_EX_MemRead = 1; rd_IDEX = 3; rs1_IFID = 3; rs1_IDEX = 3; rd_EXMEM = 3; EX_MEM_RegW = 1;
    expect_v("lu_stall1", 1); expect_v("lu_flush1", 1); expect_v("lu_stall3", 1);
    expect_v("lu_muxa", 2); expect_v("lu_cnt1_pre", 0);
    @(negedge clk);
    check_v(32'(i1.stall)); check_v(32'(i1.flush_IDEX)); check_v(32'(i3.stall));
    check_v(32'(i1.MuxA)); check_v(32'(i1.stall_count));

    next_cycle();
    ID_EX_MemRead = 0;
    expect_v("lu_c2_stall1", 0); expect_v("lu_c2_cnt1", 1); expect_v("lu_c2_stall3", 1);
    @(negedge clk); check_v(32'(i1.stall)); check_v(32'(i1.stall_count)); check_v(32'(i3.stall));

    next_cycle();
    expect_v("lu_c3_stall3", 1); expect_v("lu_c3_flush3", 1);
    @(negedge clk); check_v(32'(i3.stall)); check_v(32'(i3.flush_IDEX));

    next_cycle();
    expect_v("lu_c4_stall3", 0); expect_v("lu_c4_cnt3", 3); expect_v("lu_c4_cnt4", 1);
    @(negedge clk); check_v(32'(i3.stall)); check_v(32'(i3.stall_count)); check_v(32'(i4.stall_count));

    next_cycle();
    clear_inputs();
    ID_EX_MemRead = 1; rd_IDEX = 4; rs2_IFID = 4; rs1_IFID = 1; uses_rs2_IFID = 0;
    expect_v("rs2_off_stall1", 0); expect_v("rs2_off_stall3", 0);
    @(negedge clk); check_v(32'(i1.stall)); check_v(32'(i3.stall));

    next_cycle();
    uses_rs2_IFID = 1;
    expect_v("rs2_on_stall1", 1); expect_v("rs2_on_flush1", 1);
    @(negedge clk); check_v(32'(i1.stall)); check_v(32'(i1.flush_IDEX));

    next_cycle();
    ID_EX_MemRead = 0; uses_rs2_IFID = 0;
    expect_v("rs2_cnt1", 2); expect_v("rs2_hold3", 1);
    @(negedge clk); check_v(32'(i1.stall_count)); check_v(32'(i3.stall));

    next_cycle();
    next_cycle();
    expect_v("rs2_end_stall3", 0); expect_v("rs2_end_cnt3", 6);
    @(negedge clk); check_v(32'(i3.stall)); check_v(32'(i3.stall_count));

    // Reset asserted in the second stall cycle of LOAD_LAT=3
    next_cycle();
    clear_inputs();
    ID_EX_MemRead = 1; rd_IDEX = 3; rs1_IFID = 3;
    next_cycle();
    ID_EX_MemRead = 0;
    expect_v("mid_hold_stall3", 1);
    @(negedge clk); check_v(32'(i3.stall));
    #1 reset = 1'b1;
    #1;
    expect_v("rst_mid_stall3", 0); expect_v("rst_mid_cnt3", 0); expect_v("rst_mid_cnt1", 0);
    check_v(32'(i3.stall)); check_v(32'(i3.stall_count)); check_v(32'(i1.stall_count));
    next_cycle();
    reset = 1'b0;
    expect_v("post_rst_stall3", 0); expect_v("post_rst_cnt3", 0);
    @(negedge clk); check_v(32'(i3.stall)); check_v(32'(i3.stall_count));

    // 20 consecutive stall cycles: LOAD_LAT=3 re-triggers in each IDLE cycle after HOLD
    next_cycle();
    ID_EX_MemRead = 1; rd_IDEX = 3; rs1_IFID = 3;
    repeat (20) @(posedge clk);
    #1;
    ID_EX_MemRead = 0;
    expect_v("sat_cnt4", 15); expect_v("sat_cnt1", 20); expect_v("b2b_cnt3", 20); expect_v("sat_stall1", 0);
    @(negedge clk);
    check_v(32'(i4.stall_count)); check_v(32'(i1.stall_count));
    check_v(32'(i3.stall_count)); check_v(32'(i1.stall));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
